// File: rtl/regfile_sequencer.sv
// Instruction sequencer for the 8x10 register file and ALU; all state and outputs update on the falling CLKb edge.
// Optional SWAP opcode (0110) is compiled in with `define REGSEQ_SWAP_EN.
module regfile_sequencer #(
    parameter int OPW = 4,
    parameter int RAW = 3,
    parameter int IW  = 10
) (
    input  logic           CLKb,
    input  logic           RST,
    input  logic           EXECUTE,
    input  logic [IW-1:0]  INSTR,
    output logic           ENW,
    output logic [RAW-1:0] WRA,
    output logic           ENR0,
    output logic [RAW-1:0] RDA0,
    output logic           ENR1,
    output logic [RAW-1:0] RDA1,
    output logic [2:0]     ALU_OP,
    output logic           ALU_LDG,
    output logic [1:0]     DSEL,
    output logic           BUSY,
    output logic           DONE,
    output logic           ERR,
    output logic [2:0]     STATE_DBG
);

    localparam logic [OPW-1:0] OP_LOAD = OPW'(0);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5);
    localparam logic [OPW-1:0] OP_SWAP = OPW'(6);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RD,
        S_EX,
        S_WB,
        S_WB2,
        S_DONE
    } state_t;

    typedef struct packed {
        logic           busy;
        logic           done;
        logic           err;
        logic           enw;
        logic [RAW-1:0] wra;
        logic           enr0;
        logic [RAW-1:0] rda0;
        logic           enr1;
        logic [RAW-1:0] rda1;
        logic [2:0]     alu_op;
        logic           ldg;
        logic [1:0]     dsel;
    } outs_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ir_q, ir_d;
    outs_t          out_q;

    function automatic logic op_legal(input logic [OPW-1:0] op);
`ifdef REGSEQ_SWAP_EN
        return op <= OP_SWAP;
`else
        return op <= OP_NOT;
`endif
    endfunction

    // Moore decode; evaluated on the next state so the outputs leave the flops already settled.
    function automatic outs_t decode(input state_t s, input logic [IW-1:0] ir);
        outs_t          o;
        logic [OPW-1:0] op;
        logic [RAW-1:0] rx;
        logic [RAW-1:0] ry;
        logic           reads;
        logic           dual;
        o     = '0;
        op    = ir[IW-1 -: OPW];
        rx    = ir[2*RAW-1 -: RAW];
        ry    = ir[RAW-1:0];
        reads = ((s == S_RD) || (s == S_EX) || (s == S_WB)) && (op != OP_LOAD);
        dual  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_SWAP);
        o.busy = (s != S_IDLE);
        if (reads) begin
            o.enr0 = 1'b1;
            o.rda0 = (op == OP_MOV) ? ry : rx;
            o.enr1 = dual;
            o.rda1 = dual ? ry : '0;
        end
        if (s == S_EX) begin
            o.ldg = 1'b1;
            case (op)
                OP_ADD:  o.alu_op = 3'b000;
                OP_SUB:  o.alu_op = 3'b001;
                OP_XOR:  o.alu_op = 3'b010;
                OP_NOT:  o.alu_op = 3'b011;
                OP_SWAP: o.alu_op = 3'b100;
                default: o.alu_op = 3'b000;
            endcase
        end
        if (s == S_WB) begin
            o.enw = 1'b1;
            o.wra = rx;
            case (op)
                OP_LOAD: o.dsel = 2'b00;
                OP_MOV:  o.dsel = 2'b01;
                OP_SWAP: o.dsel = 2'b11;
                default: o.dsel = 2'b10;
            endcase
        end
`ifdef REGSEQ_SWAP_EN
        // Second write of SWAP: old Rx (held in G) into Ry.
        if (s == S_WB2) begin
            o.enw  = 1'b1;
            o.wra  = ry;
            o.dsel = 2'b10;
        end
`endif
        if (s == S_DONE) begin
            o.done = 1'b1;
            o.err  = ~op_legal(op);
        end
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (EXECUTE) begin
                    ir_d    = INSTR;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!op_legal(ir_q[IW-1 -: OPW])) begin
                    state_d = S_DONE;
                end else if (ir_q[IW-1 -: OPW] == OP_LOAD) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD:   state_d = (ir_q[IW-1 -: OPW] == OP_MOV) ? S_WB : S_EX;
            S_EX:   state_d = S_WB;
`ifdef REGSEQ_SWAP_EN
            S_WB:   state_d = (ir_q[IW-1 -: OPW] == OP_SWAP) ? S_WB2 : S_DONE;
            S_WB2:  state_d = S_DONE;
`else
            S_WB:   state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge CLKb or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            out_q   <= decode(state_d, ir_d);
        end
    end

    assign ENW       = out_q.enw;
    assign WRA       = out_q.wra;
    assign ENR0      = out_q.enr0;
    assign RDA0      = out_q.rda0;
    assign ENR1      = out_q.enr1;
    assign RDA1      = out_q.rda1;
    assign ALU_OP    = out_q.alu_op;
    assign ALU_LDG   = out_q.ldg;
    assign DSEL      = out_q.dsel;
    assign BUSY      = out_q.busy;
    assign DONE      = out_q.done;
    assign ERR       = out_q.err;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: per-instruction expected output traces built from the opcode rules,
// with random EXECUTE/INSTR noise while busy.
module tb_regfile_sequencer;

    logic       CLKb;
    logic       RST;
    logic       EXECUTE;
    logic [9:0] INSTR;
    logic       ENW;
    logic [2:0] WRA;
    logic       ENR0;
    logic [2:0] RDA0;
    logic       ENR1;
    logic [2:0] RDA1;
    logic [2:0] ALU_OP;
    logic       ALU_LDG;
    logic [1:0] DSEL;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [2:0] STATE_DBG;

    int vectors;
    int miscompares;
    logic [20:0] exp_q[$];

`ifdef REGSEQ_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    regfile_sequencer dut (
        .CLKb(CLKb), .RST(RST), .EXECUTE(EXECUTE), .INSTR(INSTR),
        .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
        .ALU_OP(ALU_OP), .ALU_LDG(ALU_LDG), .DSEL(DSEL),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .STATE_DBG(STATE_DBG)
    );

    initial begin
        CLKb = 1'b1;
        forever #5 CLKb = ~CLKb;
    end

    // Packed view of all outputs: busy done err enw wra enr0 rda0 enr1 rda1 alu_op ldg dsel
    function automatic logic [20:0] pk(input bit busy, input bit done, input bit err, input bit enw,
                                       input logic [2:0] wra, input bit enr0, input logic [2:0] rda0,
                                       input bit enr1, input logic [2:0] rda1, input logic [2:0] aop,
                                       input bit ldg, input logic [1:0] dsel);
        return {busy, done, err, enw, wra, enr0, rda0, enr1, rda1, aop, ldg, dsel};
    endfunction

    function automatic logic [20:0] observed();
        return {BUSY, DONE, ERR, ENW, WRA, ENR0, RDA0, ENR1, RDA1, ALU_OP, ALU_LDG, DSEL};
    endfunction

    // Reference: one entry per cycle from DECODE to DONE, derived from what each opcode must do.
    function automatic void build_trace(input logic [9:0] instr);
        logic [3:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [2:0] aop;
        logic [2:0] r1;
        logic [1:0] dsel;
        bit         legal;
        bit         dual;
        op    = instr[9:6];
        rx    = instr[5:3];
        ry    = instr[2:0];
        legal = (op <= 4'd5) || ((op == 4'd6) && SWAP_EN);
        exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0));
        if (!legal) begin
            exp_q.push_back(pk(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0));
            return;
        end
        if (op == 4'd0) begin
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, rx, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0));
        end else if (op == 4'd1) begin
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, ry, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0));
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, rx, 1'b1, ry, 1'b0, 3'd0, 3'd0, 1'b0, 2'd1));
        end else begin
            dual = (op == 4'd2) || (op == 4'd3) || (op == 4'd4) || (op == 4'd6);
            r1   = dual ? ry : 3'd0;
            case (op)
                4'd2:    aop = 3'd0;
                4'd3:    aop = 3'd1;
                4'd4:    aop = 3'd2;
                4'd5:    aop = 3'd3;
                default: aop = 3'd4;
            endcase
            dsel = (op == 4'd6) ? 2'd3 : 2'd2;
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, rx, dual, r1, 3'd0, 1'b0, 2'd0));
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, rx, dual, r1, aop, 1'b1, 2'd0));
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, rx, 1'b1, rx, dual, r1, 3'd0, 1'b0, dsel));
            if (op == 4'd6)
                exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, ry, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 2'd2));
        end
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0));
    endfunction

    // Called just after a rising edge with the DUT in IDLE; returns just after the rising edge of the IDLE cycle.
    task automatic run_instr(input logic [9:0] instr, input bit hold, input string name);
        logic [20:0] e;
        int          cyc;
        build_trace(instr);
        EXECUTE = 1'b1;
        INSTR   = instr;
        cyc     = 1;
        while (exp_q.size() > 0) begin
            @(posedge CLKb);
            e = exp_q.pop_front();
            vectors++;
            if (observed() !== e) begin
                miscompares++;
                $display("FAIL %s edge %0d: got %h expected %h", name, cyc, observed(), e);
            end
            EXECUTE = hold ? 1'b1 : 1'($urandom_range(0, 1));
            INSTR   = 10'($urandom);
            cyc++;
        end
        @(posedge CLKb);
        vectors++;
        if (observed() !== 21'd0) begin
            miscompares++;
            $display("FAIL %s idle-gap: got %h expected %h", name, observed(), 21'd0);
        end
        EXECUTE = 1'b0;
    endtask

    task automatic test_reset();
        RST     = 1'b1;
        EXECUTE = 1'b1;
        INSTR   = 10'b0000_101_000;
        repeat (2) @(posedge CLKb);
        vectors++;
        if (observed() !== 21'd0) begin
            miscompares++;
            $display("FAIL reset-outputs: got %h expected %h", observed(), 21'd0);
        end
        RST = 1'b0;
        run_instr(10'b0000_101_000, 1'b0, "load_r5_after_reset");
    endtask

    task automatic test_add();
        run_instr(10'b0010_010_110, 1'b0, "add_r2_r6");
    endtask

    task automatic test_back_to_back();
        run_instr(10'b0001_001_111, 1'b1, "mov_r1_r7");
        run_instr(10'b0101_100_000, 1'b1, "not_r4");
    endtask

    task automatic test_illegal();
        run_instr(10'b1111_010_001, 1'b0, "illegal_1111");
        run_instr(10'b0110_011_100, 1'b0, "opcode_0110");
    endtask

    task automatic test_reset_mid();
        EXECUTE = 1'b1;
        INSTR   = 10'b0011_000_001;
        @(posedge CLKb);
        EXECUTE = 1'b0;
        repeat (2) @(posedge CLKb);
        vectors++;
        if (ALU_LDG !== 1'b1 || ALU_OP !== 3'b001) begin
            miscompares++;
            $display("FAIL sub_ex_before_reset: got ldg=%b op=%b expected ldg=1 op=001", ALU_LDG, ALU_OP);
        end
        #1 RST = 1'b1;
        #1;
        vectors++;
        if (observed() !== 21'd0) begin
            miscompares++;
            $display("FAIL async_reset_mid_ex: got %h expected %h", observed(), 21'd0);
        end
        @(posedge CLKb);
        RST = 1'b0;
        repeat (4) begin
            @(posedge CLKb);
            vectors++;
            if (observed() !== 21'd0) begin
                miscompares++;
                $display("FAIL post_reset_quiet: got %h expected %h", observed(), 21'd0);
            end
        end
        run_instr(10'b0011_000_001, 1'b0, "sub_r0_r1_after_reset");
    endtask

    task automatic test_swap();
        run_instr(10'b0110_011_100, 1'b0, "swap_r3_r4");
        run_instr(10'b0011_011_011, 1'b0, "sub_r3_r3");
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            run_instr({op, 3'($urandom), 3'($urandom)}, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b1;
        EXECUTE     = 1'b0;
        INSTR       = 10'd0;
        @(posedge CLKb);
        test_reset();
        test_add();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_swap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
